seq_run_detector: RTL

- Parametrised Moore detector for runs of RUN_LEN consecutive matching input bits. Generalises the fixed two-1s detector in three ways: configurable run length, selectable polarity (1s or 0s), and overlapping or non-overlapping mode.
- Adds a clock-enable, a one-cycle detection strobe and a saturating detection counter.
- Sits behind a synchronised serial bit stream; its outputs feed control logic and status registers.

---
 rtl/seq_run_detector_pkg.sv | 17 +
 rtl/seq_run_detector_if.sv | 35 +++
 rtl/seq_run_detector_sat_counter.sv | 23 ++
 rtl/seq_run_detector.sv | 93 +++++++++
 4 files changed

// File: rtl/seq_run_detector_pkg.sv
// seq_run_pkg: shared width helper and types for the run detector slice.
// Contents:
//   run_w()  - bit width needed to hold a run counter value 0..run_len
//   RUN_W    - run counter width for the default run length
//   run_t    - run counter type at the default width
package seq_run_pkg;

  function automatic int run_w(input int run_len);
    return (run_len < 1) ? 1 : $clog2(run_len + 1);
  endfunction

  localparam int RUN_LEN_DEF = 2;
  localparam int RUN_W       = run_w(RUN_LEN_DEF);

  typedef logic [RUN_W-1:0] run_t;

endpackage

// File: rtl/seq_run_detector_if.sv
// seq_run_if: control/status bundle of the run detector.
// Optional macro: SEQ_RUN_STICKY_EN adds the sticky status bit.
// Signals:
//   en, w, pol, overlap, clr_cnt   - stream and control into the detector
//   z, det_pulse, run_len, det_cnt - detector status (sticky when enabled)
// Modports: master drives the stream/control, slave is the detector.
interface seq_run_if
  import seq_run_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
);
  logic                       en;
  logic                       w;
  logic                       pol;
  logic                       overlap;
  logic                       clr_cnt;
  logic                       z;
  logic                       det_pulse;
  logic [run_w(RUN_LEN)-1:0]  run_len;
  logic [CNT_W-1:0]           det_cnt;
`ifdef SEQ_RUN_STICKY_EN
  logic                       sticky;

  modport master (output en, w, pol, overlap, clr_cnt,
                  input  z, det_pulse, run_len, det_cnt, sticky);
  modport slave  (input  en, w, pol, overlap, clr_cnt,
                  output z, det_pulse, run_len, det_cnt, sticky);
`else
  modport master (output en, w, pol, overlap, clr_cnt,
                  input  z, det_pulse, run_len, det_cnt);
  modport slave  (input  en, w, pol, overlap, clr_cnt,
                  output z, det_pulse, run_len, det_cnt);
`endif
endinterface

// File: rtl/seq_run_detector_sat_counter.sv
// sat_counter: W-bit up counter that saturates at all-ones.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   inc      - count one event
//   clr      - synchronous clear; beats a simultaneous inc
//   cnt      - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_run_detector.sv
// seq_run_detector: Moore detector for runs of RUN_LEN consecutive bits equal
// to pol, with overlapping/non-overlapping modes, sample enable, a one-cycle
// detection strobe and a saturating detection counter.
// Optional macro: SEQ_RUN_STICKY_EN adds a sticky detection flag cleared by clr_cnt.
// Ports:
//   clk - clock, rst - synchronous active-high reset
//   bus (seq_run_if.slave):
//     en, w, pol, overlap, clr_cnt in; z, det_pulse, run_len, det_cnt (sticky) out
module seq_run_detector
  import seq_run_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_run_if.slave  bus
);

  localparam int RW = run_w(RUN_LEN);
  localparam logic [RW-1:0] R_FULL = RW'(RUN_LEN);
  localparam logic [RW-1:0] R_PEN  = RW'(RUN_LEN - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  logic [RW-1:0]    r, r_nxt;
  logic             pol_q;
  logic             m, det;
  logic             det_pulse_q;
  logic [CNT_W-1:0] det_cnt;

  // Next run count and detection event for the bit being sampled.
  always_comb begin
    m     = (bus.w == bus.pol);
    r_nxt = r;
    det   = 1'b0;
    if (bus.en) begin
      if (bus.pol != pol_q) begin
        // Target flipped: only the current bit can belong to the new run.
        r_nxt = m ? R_ONE : '0;
      end else if (!m) begin
        r_nxt = '0;
      end else if (r < R_PEN) begin
        r_nxt = r + 1'b1;
      end else if (r == R_PEN) begin
        r_nxt = R_FULL;
        det   = 1'b1;
      end else if (bus.overlap) begin
        det   = 1'b1;
      end else begin
        // Non-overlapping: the completed run is consumed, this bit starts anew.
        r_nxt = R_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      pol_q       <= 1'b0;
      det_pulse_q <= 1'b0;
    end else begin
      r           <= r_nxt;
      pol_q       <= bus.pol;   // tracks pol even while en=0
      det_pulse_q <= det;
    end
  end

  sat_counter #(.W(CNT_W)) u_det_cnt (
    .clk (clk),
    .rst (rst),
    .inc (det),
    .clr (bus.clr_cnt),
    .cnt (det_cnt)
  );

  assign bus.z         = (r == R_FULL);
  assign bus.det_pulse = det_pulse_q;
  assign bus.run_len   = r;
  assign bus.det_cnt   = det_cnt;

`ifdef SEQ_RUN_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (rst)              sticky_q <= 1'b0;
    else if (bus.clr_cnt) sticky_q <= 1'b0;
    else if (det)         sticky_q <= 1'b1;
  end

  assign bus.sticky = sticky_q;
`endif

endmodule
